// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM command encodings, FSM states and mode-register base
// for the game/download SDRAM controller.
package jtframe_sdram_pkg;

  // {nCS,nRAS,nCAS,nWE}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [12:0] MODE_BASE = 13'h0021;

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_REF1,
    S_INIT_REF2,
    S_INIT_MRS,
    S_IDLE,
    S_READ,
    S_WRITE,
    S_REF
  } state_e;

  // Column address with A10 set for auto-precharge
  function automatic logic [12:0] col_ap(input logic [8:0] col);
    return {4'b0010, col};
  endfunction

endpackage

// File: rtl/jtframe_sdram_refresh.sv
// Refresh interval timer: raises a sticky request every REF_CYCLES
// cycles while enabled; cleared when the controller issues REF.
module jtframe_sdram_refresh #(
  parameter int REF_CYCLES = 370
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic pending_o
);

  localparam int CW = $clog2(REF_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(REF_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          pend_q;

  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == LAST)
        pend_q <= 1'b1;
      else if (clr_i)
        pend_q <= 1'b0;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/jtframe_sdram_ctrl.sv
// SDR SDRAM controller: BL=2 game reads, single-word download writes,
// power-up init and auto refresh. All SDRAM pins are registered.
module jtframe_sdram_ctrl
  import jtframe_sdram_pkg::*;
#(
  parameter int CL          = 2,
  parameter int INIT_CYCLES = 4800,
  parameter int REF_CYCLES  = 370,
  parameter int TRFC        = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        loop_rst,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        refresh_en,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_rdy,
  output logic [31:0] data_read,
  inout  wire  [15:0] SDRAM_DQ,
  output logic [12:0] SDRAM_A,
  output logic [1:0]  SDRAM_BA,
  output logic        SDRAM_DQML,
  output logic        SDRAM_DQMH,
  output logic        SDRAM_nCS,
  output logic        SDRAM_nRAS,
  output logic        SDRAM_nCAS,
  output logic        SDRAM_nWE,
  output logic        SDRAM_CKE
);

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] TRFC_LAST = 16'(TRFC);
  localparam logic [15:0] REF_LAST  = 16'(TRFC - 1);
  localparam logic [15:0] RD_LO     = 16'(3 + CL);
  localparam logic [15:0] RD_HI     = 16'(4 + CL);
  localparam logic [12:0] MODE      = MODE_BASE | 13'(CL << 4);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] a_q, a_d;
  logic [1:0]  dqm_q, dqm_d;
  logic        oe_q, oe_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] din_q, lo_q, lo_d;
  logic        ack_q, ack_d, rdy_q, rdy_d;
  logic [31:0] data_q, data_d;
  logic        loop_q, loop_d;
  logic [8:0]  col_q, col_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [1:0]  wmsk_q, wmsk_d;

  logic        pend_q, pend_clr;
  logic [21:0] pend_addr_q;
  logic [7:0]  pend_data_q;
  logic [1:0]  pend_mask_q;
  logic        ref_pend, ref_clr;

  jtframe_sdram_refresh #(.REF_CYCLES(REF_CYCLES)) u_refresh (
    .clk       (clk),
    .rst       (rst),
    .en_i      (!loop_q),
    .clr_i     (ref_clr),
    .pending_o (ref_pend)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    cmd_d    = CMD_NOP;
    a_d      = a_q;
    dqm_d    = dqm_q;
    oe_d     = 1'b0;
    dout_d   = dout_q;
    lo_d     = lo_q;
    ack_d    = 1'b0;
    rdy_d    = 1'b0;
    data_d   = data_q;
    loop_d   = loop_q;
    col_d    = col_q;
    wdat_d   = wdat_q;
    wmsk_d   = wmsk_q;
    pend_clr = 1'b0;
    ref_clr  = 1'b0;
    unique case (state_q)
      S_INIT_WAIT: if (cnt_q == INIT_LAST) begin
        cmd_d   = CMD_PRE;
        a_d     = 13'h0400;
        cnt_d   = '0;
        state_d = S_INIT_PRE;
      end
      S_INIT_PRE: if (cnt_q == 16'd1) begin
        cmd_d   = CMD_REF;
        cnt_d   = '0;
        state_d = S_INIT_REF1;
      end
      S_INIT_REF1: if (cnt_q == TRFC_LAST) begin
        cmd_d   = CMD_REF;
        cnt_d   = '0;
        state_d = S_INIT_REF2;
      end
      S_INIT_REF2: if (cnt_q == TRFC_LAST) begin
        cmd_d   = CMD_MRS;
        a_d     = MODE;
        cnt_d   = '0;
        state_d = S_INIT_MRS;
      end
      S_INIT_MRS: if (cnt_q == 16'd2) begin
        state_d = S_IDLE;
        loop_d  = 1'b0;
      end
      S_IDLE: begin
        cnt_d = '0;
        // downloads first, refresh next, game reads last
        if (pend_q) begin
          cmd_d    = CMD_ACT;
          a_d      = pend_addr_q[21:9];
          col_d    = pend_addr_q[8:0];
          wdat_d   = pend_data_q;
          wmsk_d   = pend_mask_q;
          pend_clr = 1'b1;
          state_d  = S_WRITE;
        end else if (ref_pend && (refresh_en || downloading)) begin
          cmd_d   = CMD_REF;
          ref_clr = 1'b1;
          state_d = S_REF;
        end else if (sdram_req && !downloading) begin
          cmd_d   = CMD_ACT;
          a_d     = sdram_addr[21:9];
          col_d   = sdram_addr[8:0];
          ack_d   = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == 16'd1) begin
          cmd_d = CMD_RD;
          a_d   = col_ap(col_q);
          dqm_d = 2'b00;
        end
        if (cnt_q == RD_LO)
          lo_d = din_q;
        if (cnt_q == RD_HI) begin
          data_d  = {din_q, lo_q};
          rdy_d   = 1'b1;
          dqm_d   = 2'b11;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (cnt_q == 16'd1) begin
          cmd_d  = CMD_WR;
          a_d    = col_ap(col_q);
          oe_d   = 1'b1;
          dout_d = {wdat_q, wdat_q};
          dqm_d  = wmsk_q;
        end
        // mask the second beat of the BL=2 write burst
        if (cnt_q == 16'd2)
          dqm_d = 2'b11;
        if (cnt_q == 16'd4)
          state_d = S_IDLE;
      end
      S_REF: if (cnt_q == REF_LAST)
        state_d = S_IDLE;
      default: state_d = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      a_q     <= '0;
      dqm_q   <= 2'b11;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      din_q   <= '0;
      lo_q    <= '0;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      loop_q  <= 1'b1;
      col_q   <= '0;
      wdat_q  <= '0;
      wmsk_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      dqm_q   <= dqm_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      din_q   <= SDRAM_DQ;
      lo_q    <= lo_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      loop_q  <= loop_d;
      col_q   <= col_d;
      wdat_q  <= wdat_d;
      wmsk_q  <= wmsk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
    end else if (prog_we) begin
      pend_q      <= 1'b1;
      pend_addr_q <= prog_addr;
      pend_data_q <= prog_data;
      pend_mask_q <= prog_mask;
    end else if (pend_clr) begin
      pend_q <= 1'b0;
    end
  end

  a_prog_overrun: assert property (
    @(posedge clk) disable iff (rst) !(prog_we && pend_q));

  assign SDRAM_DQ   = oe_q ? dout_q : 16'hzzzz;
  assign SDRAM_A    = a_q;
  assign SDRAM_BA   = 2'b00;
  assign SDRAM_DQML = dqm_q[0];
  assign SDRAM_DQMH = dqm_q[1];
  assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd_q;
  assign SDRAM_CKE  = 1'b1;
  assign sdram_ack  = ack_q;
  assign data_rdy   = rdy_q;
  assign data_read  = data_q;
  assign loop_rst   = loop_q;

endmodule

// File: tb/tb_jtframe_sdram_ctrl.sv
// Directed bench for jtframe_sdram_ctrl against a small behavioural
// SDR SDRAM (bank 0 only, CL=2, single-word writes).
module tb_jtframe_sdram_ctrl;
  import jtframe_sdram_pkg::*;

  localparam int CL   = 2;
  localparam int INIT = 40;
  localparam int REFC = 400;
  localparam int TRFC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loop_rst;
  logic        downloading = 1'b0;
  logic        prog_we = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [1:0]  prog_mask = '0;
  logic        refresh_en = 1'b0;
  logic        sdram_req = 1'b0;
  logic [21:0] sdram_addr = '0;
  logic        sdram_ack, data_rdy;
  logic [31:0] data_read;
  wire  [15:0] dq;
  logic [12:0] A;
  logic [1:0]  BA;
  logic        dqml, dqmh, ncs, nras, ncas, nwe, cke;
  logic [3:0]  cmd;

  always #5 clk = ~clk;

  jtframe_sdram_ctrl #(
    .CL(CL), .INIT_CYCLES(INIT), .REF_CYCLES(REFC), .TRFC(TRFC)
  ) dut (
    .clk(clk), .rst(rst), .loop_rst(loop_rst),
    .downloading(downloading), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .refresh_en(refresh_en),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read), .SDRAM_DQ(dq), .SDRAM_A(A),
    .SDRAM_BA(BA), .SDRAM_DQML(dqml), .SDRAM_DQMH(dqmh),
    .SDRAM_nCS(ncs), .SDRAM_nRAS(nras), .SDRAM_nCAS(ncas),
    .SDRAM_nWE(nwe), .SDRAM_CKE(cke)
  );

  assign cmd = {ncs, nras, ncas, nwe};

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // behavioural SDRAM
  logic [15:0] mem [logic [21:0]];
  logic [12:0] mrow = '0;
  logic [21:0] raddr = '0;
  int          rk = 0;
  logic        mdl_oe = 1'b0;
  logic [15:0] mdl_q = '0;
  logic [21:0] wa;
  logic [15:0] ww;

  assign dq = mdl_oe ? mdl_q : 16'hzzzz;

  function automatic logic [15:0] rdw(input logic [21:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    mdl_oe <= 1'b0;
    if (rk == CL - 1) begin
      mdl_oe <= 1'b1;
      mdl_q  <= rdw(raddr);
    end else if (rk == CL) begin
      mdl_oe <= 1'b1;
      mdl_q  <= rdw(raddr ^ 22'd1);
    end
    if (cmd == CMD_RD) begin
      raddr <= {mrow, A[8:0]};
      rk    <= 1;
    end else if (rk != 0) begin
      rk <= (rk == CL) ? 0 : rk + 1;
    end
    if (cmd == CMD_ACT)
      mrow <= A;
    if (cmd == CMD_WR) begin
      wa = {mrow, A[8:0]};
      ww = rdw(wa);
      if (!dqml) ww[7:0] = dq[7:0];
      if (!dqmh) ww[15:8] = dq[15:8];
      mem[wa] = ww;
    end
  end

  logic [16:0] log_q[$];
  always @(negedge clk)
    if (cmd !== CMD_NOP) log_q.push_back({cmd, A});

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic prog(input logic [21:0] a, input logic [7:0] d,
                      input logic [1:0] m);
    prog_we = 1'b1; prog_addr = a; prog_data = d; prog_mask = m;
    @(negedge clk);
    prog_we = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [21:0] a,
                    input logic [31:0] exp, output int alat);
    int n;
    sdram_req = 1'b1; sdram_addr = a; n = 0;
    do begin @(negedge clk); n++; end
    while (!sdram_ack && n < 1000);
    alat = n;
    sdram_req = 1'b0;
    chk({tag, " ack"}, sdram_ack, 1);
    @(negedge clk);
    chk({tag, " ackpulse"}, sdram_ack, 0);
    n = 1;
    while (!data_rdy && n < 50) begin @(negedge clk); n++; end
    chk({tag, " rdylat"}, n, 7);
    chk({tag, " data"}, data_read, exp);
  endtask

  task automatic wait_init(input string tag);
    int n, rdys;
    n = 0; rdys = 0;
    while (loop_rst && n < INIT + 100) begin
      @(negedge clk); n++;
      if (data_rdy) rdys++;
    end
    chk({tag, " initlen"}, n, INIT + 15);
    chk({tag, " no rdy"}, rdys, 0);
    chk({tag, " ncmd"}, log_q.size(), 4);
    chk({tag, " pre"}, log_q[0][16:13], CMD_PRE);
    chk({tag, " pre a10"}, log_q[0][10], 1);
    chk({tag, " ref1"}, log_q[1][16:13], CMD_REF);
    chk({tag, " ref2"}, log_q[2][16:13], CMD_REF);
    chk({tag, " mrs"}, log_q[3][16:13], CMD_MRS);
    chk({tag, " mode"}, log_q[3][12:0], 13'h0021);
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, " cmd"}, cmd, CMD_NOP);
    chk({tag, " A"}, A, 0);
    chk({tag, " dqm"}, {dqmh, dqml}, 2'b11);
    chk({tag, " ack"}, sdram_ack, 0);
    chk({tag, " rdy"}, data_rdy, 0);
    chk({tag, " data"}, data_read, 0);
    chk({tag, " loop_rst"}, loop_rst, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int alat, n, acks, t_init, nref;

    // reset and power-up init
    rst = 1'b1;
    @(negedge clk);
    chk_rst_vals("rst");
    chk("cke", cke, 1);
    rst = 1'b0;
    log_q.delete();
    wait_init("init");
    t_init = cyc;

    // download writes then readback
    downloading = 1'b1;
    prog(22'h000100, 8'hA5, 2'b00);
    prog(22'h000101, 8'h5A, 2'b00);
    prog(22'h000010, 8'hFF, 2'b00);
    prog(22'h000011, 8'h12, 2'b00);
    prog(22'h000010, 8'h3C, 2'b01);
    downloading = 1'b0;
    @(negedge clk);
    rd("rd100", 22'h000100, 32'h5A5AA5A5, alat);
    chk("rd100 acklat", alat, 1);
    rd("rd101", 22'h000101, 32'hA5A55A5A, alat);
    repeat (5) @(negedge clk);
    chk("hold data", data_read, 32'hA5A55A5A);
    rd("rd010 mask", 22'h000010, 32'h12123CFF, alat);

    // reads blocked while downloading
    downloading = 1'b1;
    sdram_req = 1'b1; sdram_addr = 22'h000100; acks = 0;
    repeat (100) begin
      @(negedge clk);
      if (sdram_ack) acks++;
    end
    chk("dl noack", acks, 0);
    downloading = 1'b0; n = 0;
    do begin @(negedge clk); n++; end
    while (!sdram_ack && n < 20);
    sdram_req = 1'b0;
    chk("dl release ack", (n >= 1 && n <= 2), 1);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!data_rdy && n < 20);
    chk("dl release data", data_read, 32'h5A5AA5A5);

    // refresh vs read arbitration
    while (cyc - t_init < REFC + 10) @(negedge clk);
    log_q.delete();
    refresh_en = 1'b1;
    rd("refen", 22'h000101, 32'hA5A55A5A, alat);
    refresh_en = 1'b0;
    chk("refen first", log_q[0][16:13], CMD_REF);
    chk("refen acklat", alat, TRFC + 2);
    t_init = cyc;
    while (cyc - t_init < REFC + 10) @(negedge clk);
    log_q.delete();
    rd("refdis", 22'h000100, 32'h5A5AA5A5, alat);
    chk("refdis acklat", alat, 1);
    nref = 0;
    foreach (log_q[i]) if (log_q[i][16:13] == CMD_REF) nref++;
    chk("refdis noref", nref, 0);

    // reset during READ command
    sdram_req = 1'b1; sdram_addr = 22'h000100; n = 0;
    while (n < 30 && cmd != CMD_RD) begin
      @(negedge clk); n++;
      if (sdram_ack) sdram_req = 1'b0;
    end
    chk("t6 rd seen", cmd, CMD_RD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sdram_req = 1'b0;
    chk_rst_vals("midrst");
    log_q.delete();
    wait_init("reinit");
    rd("post rst", 22'h000100, 32'h5A5AA5A5, alat);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
